// File: rtl/pi_scheduler.sv
// ---------------------------------------------------------------------------
// pi_scheduler
// Time-multiplexed PI controller: one multiply/accumulate datapath shared by
// up to N_CH control loops. A round-robin arbiter picks one requesting loop,
// then a five-state FSM (IDLE, PROP, INTEG, SAT, OUT) computes the
// proportional term, the saturating integrator update, the output clamp and
// the anti-windup residue against that loop's stored state.
//
// Optional feature macro: PI_SCHED_AW_EN
//   defined   : back-calculation anti-windup, per-channel aw[] registers
//   undefined : aw term is zero, no aw[] storage; integrator still saturates
//
// Ports
//   i_CLK    in   clock, rising edge
//   i_RST    in   asynchronous active-low reset
//   i_VALID  in   [N_CH]      per-channel request
//   i_ERR    in   [32*N_CH]   packed signed errors, channel c at [32c+:32]
//   o_READY  out  [N_CH]      one-hot grant, combinational, only in IDLE
//   i_CLR    in   [N_CH]      per-channel clear of integrator / aw state
//   o_VALID  out  1           one-cycle strobe, o_PI / o_CH valid
//   o_PI     out  [32]        clamped signed controller output (held)
//   o_CH     out  [CW]        channel that produced o_PI
// ---------------------------------------------------------------------------
module pi_scheduler #(
  parameter int unsigned N_CH      = 4,
  parameter int          KP        = 1,
  parameter int          TSKI      = 1,
  parameter int          KAW       = 1,
  parameter int unsigned SHIFT_KP  = 0,
  parameter int unsigned SHIFT_KI  = 0,
  parameter int unsigned SHIFT_KAW = 0,
  parameter int          SAT_MAX   = 1000000,
  parameter int          SAT_MIN   = -1000000,
  localparam int unsigned CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [N_CH-1:0]      i_VALID,
  input  logic [32*N_CH-1:0]   i_ERR,
  output logic [N_CH-1:0]      o_READY,
  input  logic [N_CH-1:0]      i_CLR,
  output logic                 o_VALID,
  output logic [31:0]          o_PI,
  output logic [CW-1:0]        o_CH
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROP  = 3'd1,
    S_INTEG = 3'd2,
    S_SAT   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic signed [65:0] L_I32_MAX = 66'sd2147483647;
  localparam logic signed [65:0] L_I32_MIN = -66'sd2147483648;
  // Integrator range is symmetric so its negation can never overflow.
  localparam logic signed [65:0] L_N_MIN   = -66'sd2147483647;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_last;
  logic [CW-1:0]           r_ch;
  logic signed [31:0]      r_err;
  logic signed [31:0]      r_integ_s;
  logic signed [31:0]      r_p;
  logic signed [31:0]      r_n;
  logic                    r_clr_pend;
  logic signed [31:0]      r_integ [N_CH];

  logic [CW-1:0]           w_cand [N_CH];
  logic                    w_gnt_any;
  logic [CW-1:0]           w_gnt_idx;
  logic                    w_hs;
  logic signed [31:0]      w_err_ch [N_CH];

  logic signed [63:0]      w_p_prod;
  logic signed [31:0]      w_p;
  logic signed [63:0]      w_aw_term;
  logic signed [65:0]      w_n_sum;
  logic signed [31:0]      w_n;
  logic signed [63:0]      w_i_prod;
  logic signed [65:0]      w_u_sum;
  logic signed [31:0]      w_u;
  logic signed [31:0]      w_u_sat;

`ifdef PI_SCHED_AW_EN
  // u - u_sat needs 33 bits when the clamp window sits off-centre.
  logic signed [32:0]      r_aw [N_CH];
  logic signed [32:0]      r_aw_s;
  logic signed [32:0]      w_aw_new;
  logic signed [63:0]      w_aw_prod;
`endif

  // Split the packed error bus into per-channel words.
  always_comb begin : err_unpack
    for (int c = 0; c < int'(N_CH); c++) begin
      w_err_ch[c] = i_ERR[32*c +: 32];
    end
  end

  // Round-robin search starting at last+1; lowest offset wins.
  always_comb begin : arb
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      w_cand[k] = CW'((32'(r_last) + 32'(k) + 32'd1) % N_CH);
    end
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (i_VALID[w_cand[k]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[k];
      end
    end
  end

  // Next-state and grant; grant is suppressed while reset is asserted.
  always_comb begin : fsm_comb
    w_state_nxt = r_state;
    o_READY     = '0;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_RST && w_gnt_any) begin
          o_READY[w_gnt_idx] = 1'b1;
          w_hs               = 1'b1;
          w_state_nxt        = S_PROP;
        end
      end
      S_PROP:  w_state_nxt = S_INTEG;
      S_INTEG: w_state_nxt = S_SAT;
      S_SAT:   w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared arithmetic for the PROP, INTEG and SAT steps.
  always_comb begin : datapath
    w_p_prod = 64'(r_err) * 64'(KP);
    w_p      = 32'(w_p_prod >>> SHIFT_KP);

`ifdef PI_SCHED_AW_EN
    w_aw_prod = 64'(r_aw_s) * 64'(KAW);
    w_aw_term = w_aw_prod >>> SHIFT_KAW;
`else
    // No anti-windup: the term is identically zero; the gain stays in the
    // expression so both builds accept the same parameter set.
    w_aw_term = (64'(KAW) >>> SHIFT_KAW) & 64'sd0;
`endif

    w_n_sum = 66'(r_integ_s) + 66'(r_err) - 66'(w_aw_term);
    if (w_n_sum > L_I32_MAX) begin
      w_n = 32'sh7fffffff;
    end else if (w_n_sum < L_N_MIN) begin
      w_n = -32'sh7fffffff;
    end else begin
      w_n = 32'(w_n_sum);
    end

    w_i_prod = 64'(r_n) * 64'(TSKI);
    w_u_sum  = 66'(r_p) + 66'(w_i_prod >>> SHIFT_KI);
    if (w_u_sum > L_I32_MAX) begin
      w_u = 32'sh7fffffff;
    end else if (w_u_sum < L_I32_MIN) begin
      w_u = 32'sh80000000;
    end else begin
      w_u = 32'(w_u_sum);
    end

    if (w_u > SAT_MAX) begin
      w_u_sat = SAT_MAX;
    end else if (w_u < SAT_MIN) begin
      w_u_sat = SAT_MIN;
    end else begin
      w_u_sat = w_u;
    end

`ifdef PI_SCHED_AW_EN
    w_aw_new = 33'(w_u) - 33'(w_u_sat);
`endif
  end

  // FSM state, in-flight sample context and registered outputs.
  always_ff @(posedge i_CLK or negedge i_RST) begin : seq
    if (!i_RST) begin
      r_state    <= S_IDLE;
      r_last     <= CW'(N_CH - 1);
      r_ch       <= '0;
      r_err      <= '0;
      r_integ_s  <= '0;
      r_p        <= '0;
      r_n        <= '0;
      r_clr_pend <= 1'b0;
      o_VALID    <= 1'b0;
      o_PI       <= '0;
      o_CH       <= '0;
`ifdef PI_SCHED_AW_EN
      r_aw_s     <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      o_VALID <= (w_state_nxt == S_OUT);

      // Integrator / aw are snapshotted at the grant so a clear arriving
      // mid-flight never alters the output of the sample in progress.
      if (w_hs) begin
        r_ch       <= w_gnt_idx;
        r_last     <= w_gnt_idx;
        r_err      <= w_err_ch[w_gnt_idx];
        r_integ_s  <= r_integ[w_gnt_idx];
        r_clr_pend <= i_CLR[w_gnt_idx];
`ifdef PI_SCHED_AW_EN
        r_aw_s     <= r_aw[w_gnt_idx];
`endif
      end else if (((r_state == S_PROP) || (r_state == S_INTEG)) && i_CLR[r_ch]) begin
        r_clr_pend <= 1'b1;
      end

      if (r_state == S_PROP) begin
        r_p <= w_p;
      end
      if (r_state == S_INTEG) begin
        r_n <= w_n;
      end
      if (r_state == S_SAT) begin
        o_PI <= w_u_sat;
        o_CH <= r_ch;
      end
    end
  end

  // Per-channel state; a clear seen any time during flight blocks writeback.
  always_ff @(posedge i_CLK or negedge i_RST) begin : chan_state
    if (!i_RST) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        r_integ[k] <= '0;
`ifdef PI_SCHED_AW_EN
        r_aw[k]    <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < int'(N_CH); k++) begin
        if (i_CLR[k]) begin
          r_integ[k] <= '0;
`ifdef PI_SCHED_AW_EN
          r_aw[k]    <= '0;
`endif
        end else if ((r_state == S_SAT) && (r_ch == CW'(k)) && !r_clr_pend) begin
          r_integ[k] <= r_n;
`ifdef PI_SCHED_AW_EN
          r_aw[k]    <= w_aw_new;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pi_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pi_scheduler
// Directed and randomized checks of pi_scheduler (N_CH=4, KP=2, TSKI=1,
// KAW=1, shifts 0, clamp +/-100) against a behavioural arithmetic model.
// Honours PI_SCHED_AW_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_pi_scheduler;

  localparam int          N    = 4;
  localparam int          KP   = 2;
  localparam int          TSKI = 1;
  localparam int          KAW  = 1;
  localparam int unsigned SHK  = 0;
  localparam int unsigned SHI  = 0;
  localparam int unsigned SHA  = 0;
  localparam int          SMAX = 100;
  localparam int          SMIN = -100;

  logic              i_CLK;
  logic              i_RST;
  logic [N-1:0]      i_VALID;
  logic [32*N-1:0]   i_ERR;
  logic [N-1:0]      o_READY;
  logic [N-1:0]      i_CLR;
  logic              o_VALID;
  logic [31:0]       o_PI;
  logic [1:0]        o_CH;

  pi_scheduler #(
    .N_CH(N), .KP(KP), .TSKI(TSKI), .KAW(KAW),
    .SHIFT_KP(SHK), .SHIFT_KI(SHI), .SHIFT_KAW(SHA),
    .SAT_MAX(SMAX), .SAT_MIN(SMIN)
  ) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_VALID(i_VALID), .i_ERR(i_ERR),
    .o_READY(o_READY), .i_CLR(i_CLR), .o_VALID(o_VALID), .o_PI(o_PI),
    .o_CH(o_CH)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  int           n_err = 0;
  int           n_chk = 0;

  // Reference state
  longint       m_integ [N];
  longint       m_aw    [N];
  int           m_last;

  // Requester state
  logic [N-1:0] pend;
  logic [31:0]  err_of  [N];
  int           wait_g  [N];
  time          hs_t, prev_hs;
  logic [31:0]  got_pi;
  logic [N-1:0] got_rdy;
  logic [N-1:0] clr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint x, input longint lo, input longint hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic int model_arb(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_integ[c] = 0;
      m_aw[c]    = 0;
      wait_g[c]  = 0;
    end
    m_last = N - 1;
  endtask

  // One PI evaluation from the arithmetic rules, updating channel state.
  task automatic model_step(input int c, input logic [31:0] e, output logic [31:0] pi);
    longint err, p, term, n, u, us;
    err = longint'($signed(e));
    p   = longint'(int'((err * KP) >>> SHK));
`ifdef PI_SCHED_AW_EN
    term = (m_aw[c] * KAW) >>> SHA;
`else
    term = 0;
`endif
    n  = clamp(m_integ[c] + err - term, -64'sd2147483647, 64'sd2147483647);
    u  = clamp(p + ((n * TSKI) >>> SHI), -64'sd2147483648, 64'sd2147483647);
    us = clamp(u, SMIN, SMAX);
    m_integ[c] = n;
    m_aw[c]    = u - us;
    m_last     = c;
    pi         = us[31:0];
  endtask

  function automatic logic [31:0] rand_err();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 600)) - 32'd300;
  endfunction

  // One transaction from an IDLE negedge to the IDLE negedge after OUT.
  task automatic serve(input bit keep, input logic [N-1:0] clr_p,
                       input logic [N-1:0] clr_i, input bit do_rst);
    logic [31:0]  exp_pi;
    logic [N-1:0] exp_rdy;
    int           g;
    i_VALID = pend;
    for (int c = 0; c < N; c++) i_ERR[32*c +: 32] = err_of[c];
    #1;
    g = model_arb(pend);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    got_rdy = o_READY;
    check("ready_grant", 64'(o_READY), 64'(exp_rdy));
    if (g < 0) return;
    check("starvation_bound", 64'(wait_g[g] < N), 64'd1);
    for (int c = 0; c < N; c++) if (pend[c] && c != g) wait_g[c]++;
    wait_g[g] = 0;

    @(posedge i_CLK);
    prev_hs = hs_t;
    hs_t    = $time;
    model_step(g, err_of[g], exp_pi);

    @(negedge i_CLK);                       // PROP
    if (!keep) pend[g] = 1'b0;
    i_VALID = pend;
    i_CLR   = clr_p;
    check("ready_busy", 64'(o_READY), 64'd0);
    check("valid_prop", 64'(o_VALID), 64'd0);
    @(negedge i_CLK);                       // INTEG
    i_CLR = clr_i;
    check("valid_integ", 64'(o_VALID), 64'd0);
    @(negedge i_CLK);                       // SAT
    i_CLR = '0;
    for (int c = 0; c < N; c++) begin
      if (clr_p[c] || clr_i[c]) begin
        m_integ[c] = 0;
        m_aw[c]    = 0;
      end
    end
    if (do_rst) begin
      i_RST = 1'b0;
      #1;
      check("rst_valid", 64'(o_VALID), 64'd0);
      check("rst_pi",    64'(o_PI),    64'd0);
      check("rst_ch",    64'(o_CH),    64'd0);
      check("rst_ready", 64'(o_READY), 64'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge i_CLK);
        check("rst_hold_valid", 64'(o_VALID), 64'd0);
        check("rst_hold_ready", 64'(o_READY), 64'd0);
      end
      i_RST = 1'b1;
      model_reset();
      return;
    end
    check("valid_sat", 64'(o_VALID), 64'd0);
    @(negedge i_CLK);                       // OUT
    got_pi = o_PI;
    check("valid_out", 64'(o_VALID), 64'd1);
    check("pi_out",    64'(o_PI),    64'(exp_pi));
    check("ch_out",    64'(o_CH),    64'(g));
    @(negedge i_CLK);                       // IDLE again
    check("valid_drop", 64'(o_VALID), 64'd0);
    check("pi_hold",    64'(o_PI),    64'(exp_pi));
  endtask

  initial begin
    i_RST   = 1'b1;
    i_VALID = '0;
    i_ERR   = '0;
    i_CLR   = '0;
    pend    = '0;
    hs_t    = 0;
    prev_hs = 0;
    for (int c = 0; c < N; c++) err_of[c] = '0;
    model_reset();

    // Reset state, with requests present to show the grant is held off
    #1 i_RST = 1'b0;
    i_VALID = '1;
    #1;
    check("reset_valid", 64'(o_VALID), 64'd0);
    check("reset_pi",    64'(o_PI),    64'd0);
    check("reset_ch",    64'(o_CH),    64'd0);
    check("reset_ready", 64'(o_READY), 64'd0);
    i_VALID = '0;
    @(negedge i_CLK);
    i_RST = 1'b1;

    // Single channel, two samples of err=10
    pend = 4'b0001; err_of[0] = 32'd10;
    serve(1'b0, '0, '0, 1'b0);
    check("single_first", 64'(got_pi), 64'd30);
    pend = 4'b0001;
    serve(1'b0, '0, '0, 1'b0);
    check("single_second", 64'(got_pi), 64'd40);

    // Fairness with every channel requesting continuously
    pend = '1;
    for (int c = 0; c < N; c++) err_of[c] = 32'(c * 5 + 1);
    for (int i = 0; i < 5; i++) begin
      serve(1'b1, '0, '0, 1'b0);
      if (i > 0) check("fair_gap", 64'((hs_t - prev_hs) / 10), 64'd5);
    end
    pend = 4'b0100;
    serve(1'b0, '0, '0, 1'b0);
    check("solo_gap", 64'((hs_t - prev_hs) / 10), 64'd5);

    // Saturation and anti-windup on ch1
    pend = 4'b0010; err_of[1] = 32'd200;
    serve(1'b0, '0, '0, 1'b0);
    pend = 4'b0010; err_of[1] = 32'd0;
    serve(1'b0, '0, '0, 1'b0);

    // Clear colliding with an in-flight ch1 sample, then a fresh sample
    pend = 4'b0010; err_of[1] = 32'd7;
    serve(1'b0, '0, 4'b0010, 1'b0);
    pend = 4'b0010; err_of[1] = 32'd5;
    serve(1'b0, '0, '0, 1'b0);
    check("after_clear", 64'(got_pi), 64'd15);

    // Integrator limit with maximal positive error on ch3
    for (int i = 0; i < 4; i++) begin
      pend = 4'b1000; err_of[3] = 32'h7fffffff;
      serve(1'b0, '0, '0, 1'b0);
    end
    pend = 4'b1000; err_of[3] = 32'h80000001;
    serve(1'b0, '0, '0, 1'b0);

    // Randomized requests, errors and side clears
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
          pend[c]   = 1'b1;
          err_of[c] = rand_err();
          wait_g[c] = 0;
        end
      end
      if (pend == '0) begin
        pend[0] = 1'b1; err_of[0] = rand_err(); wait_g[0] = 0;
      end
      clr = ($urandom_range(0, 4) == 0) ? N'($urandom_range(0, 15)) : '0;
      serve(1'b0, clr, '0, 1'b0);
    end

    // Reset during SAT, then the first grant must go to ch0
    pend = '1;
    for (int c = 0; c < N; c++) err_of[c] = 32'(c + 3);
    serve(1'b1, '0, '0, 1'b1);
    pend = '1;
    serve(1'b0, '0, '0, 1'b0);
    check("grant_after_reset", 64'(got_rdy), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
